dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder on the far end of the load/store address path.
- Accepts one word request per handshake: a byte address from the address-generation stage, a write flag and write data.
- Completes the request after a fixed multi-cycle latency and returns read data or a write acknowledge, with an error flag.
- The pipeline holds the MEM stage on `busy` until `resp_valid` arrives.

Parameters:
- DEPTH, 512, number of 16-bit words in the backing array; power of two, 2..32768.
- LATENCY, 4, cycles from the request cycle to the response cycle; must be at least 1.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  request present this cycle.
- req_write  input  1  1 = store word, 0 = load word.
- req_addr  input  16  byte address, unsigned.
- req_wdata  input  16  store data.
- req_ready  output  1  responder idle; the request is accepted when req_valid && req_ready at the clock edge.
- resp_valid  output  1  one-cycle pulse; response for the accepted request.
- resp_rdata  output  16  load data; 0 for stores and for errored loads.
- resp_err  output  1  valid with resp_valid: misaligned or out-of-range address.
- busy  output  1  equals ~req_ready; used as the pipeline stall.

Behaviour:
- All outputs are registered. Reset values: req_ready=1, busy=0, resp_valid=0, resp_rdata=16'h0000, resp_err=0, FSM in IDLE, latency counter 0.
- Reset does not clear the memory array.
- FSM states are IDLE, WAIT and RESP.
- IDLE:
  - req_ready=1.
  - On accept, latch write flag, word index req_addr[15:1], req_wdata, misalign = req_addr[0], and range_err = (req_addr[15:1] >= DEPTH).
  - Go to WAIT, or to RESP directly if LATENCY==1.
  - With req_valid=0, stay in IDLE.
- WAIT: req_ready=0. The counter counts the remaining cycles, and the FSM enters RESP so that the timing below is exact.
- Timing, with the accept cycle numbered 0:
  - req_ready=0 in cycles 1..LATENCY.
  - resp_valid=1 in cycle LATENCY only.
  - req_ready=1 again in cycle LATENCY+1.
  - Throughput is one request per LATENCY+1 cycles.
- RESP (one cycle), then return to IDLE:
  - resp_valid=1 and resp_err = misalign | range_err.
  - Load without error: resp_rdata = mem[index].
  - Store, or any error: resp_rdata = 0.
  - A store without error commits mem[index] = wdata at the edge ending the RESP cycle. A load accepted afterwards returns the new value.
  - A misaligned or out-of-range store is dropped and memory is unchanged.
- Address rule: word index = req_addr[15:1]. Bit 0 never selects a byte; it only raises resp_err. A misaligned load with an in-range index still returns 0, not data.
- Inputs are ignored while req_ready=0. Changes to req_addr, req_wdata or req_valid during WAIT or RESP have no effect; latched values are used.
- Reset mid-operation, in any state: next cycle is IDLE with reset output values. The pending store is not committed and no resp_valid is issued for the aborted request.
- If rst and req_valid are both high in an IDLE cycle, rst wins and nothing is accepted.

Test Plan:
- Basic store/load:
  - LATENCY=4. Store 16'hBEEF at addr 16'h0010 in cycle 0 -> req_ready low in cycles 1-4, resp_valid in cycle 4 with rdata=0 and err=0.
  - Load 16'h0010 accepted in cycle 5 -> resp_valid in cycle 9 with rdata=16'hBEEF.
- Misaligned access:
  - Store 16'h1234 at addr 16'h0021 -> resp_err=1, memory word 16 unchanged.
  - Load addr 16'h0021 -> resp_err=1, rdata=0.
  - Load addr 16'h0020 -> original contents of word 16.
- Out of range:
  - DEPTH=512. Load addr 16'h0400 (word 512) -> resp_err=1, rdata=0.
  - Store to 16'h03FE (word 511) then load 16'h03FE -> data returned, err=0.
- Hold and ignore inputs:
  - Keep req_valid=1 with changing addr during cycles 1-4 -> only the cycle-0 request completes; the next accept happens no earlier than cycle 5.
  - resp_valid is exactly one cycle wide.
- Reset mid-op:
  - Store 16'hAAAA to 16'h0008, assert rst in cycle 2 -> no resp_valid, req_ready=1 after reset.
  - A following load of 16'h0008 returns the pre-store value.
- LATENCY=1 build: back-to-back store then load to the same address -> responses in cycles 1 and 3; the load returns the stored data.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder for the load/store path.
// Takes one word request per handshake, answers after a fixed LATENCY
// (accept cycle = 0, response cycle = LATENCY) and holds the pipeline
// through `busy` meanwhile. Misaligned or out-of-range requests answer
// with resp_err and never touch the array.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | ready for a request; accepts on req_valid && req_ready
// WAIT  | request latched, counting down the remaining latency cycles
// RESP  | one-cycle response; an error-free store commits at its end
module dmem_responder #(
    parameter int unsigned DEPTH   = 512,
    parameter int unsigned LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [15:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);

    localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW       = $clog2(LATENCY + 1);
    // WAIT occupies cycles 1..LATENCY-1; the counter holds the WAIT
    // cycles still to come after the current one.
    localparam int unsigned CNT_LOAD = (LATENCY > 1) ? LATENCY - 2 : 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_nxt;
    logic            accept;

    logic            write_q;
    logic            err_q;
    logic [AW-1:0]   idx_q;
    logic [15:0]     wdata_q;

    logic            new_err;
    logic [AW-1:0]   new_idx;
    logic            cur_write;
    logic            cur_err;
    logic [AW-1:0]   cur_idx;

    logic [15:0]     mem [DEPTH];

    // Decode the incoming request and pick the request the response is
    // built from (the one being accepted when LATENCY is 1).
    always_comb begin
        new_idx   = req_addr[AW:1];
        new_err   = req_addr[0] | (32'(req_addr[15:1]) >= DEPTH);
        cur_write = accept ? req_write : write_q;
        cur_err   = accept ? new_err   : err_q;
        cur_idx   = accept ? new_idx   : idx_q;
    end

    // Next-state and latency counter logic.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    accept = 1'b1;
                    if (LATENCY == 1) begin
                        state_nxt = RESP;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = CW'(CNT_LOAD);
                    end
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_nxt = RESP;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Capture the request on accept; later input changes are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            write_q <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            write_q <= req_write;
            err_q   <= new_err;
            idx_q   <= new_idx;
            wdata_q <= req_wdata;
        end
    end

    // Registered outputs, computed from the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_ready  <= 1'b1;
            busy       <= 1'b0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
        end else begin
            req_ready  <= (state_nxt == IDLE);
            busy       <= (state_nxt != IDLE);
            resp_valid <= (state_nxt == RESP);
            resp_err   <= (state_nxt == RESP) && cur_err;
            resp_rdata <= ((state_nxt == RESP) && !cur_write && !cur_err) ?
                          mem[cur_idx] : 16'h0000;
        end
    end

    // Store commit at the edge ending RESP; reset aborts the store and
    // never clears the array.
    always_ff @(posedge clk) begin
        if (!rst && (state == RESP) && write_q && !err_q) begin
            mem[idx_q] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios plus randomized requests,
// all checked against a word-array reference model.
module tb_dmem_responder;

    localparam int DEPTH = 512;
    localparam int LAT   = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_write;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        req_ready;
    logic        resp_valid;
    logic [15:0] resp_rdata;
    logic        resp_err;
    logic        busy;

    logic        l1_req_valid;
    logic        l1_req_write;
    logic [15:0] l1_req_addr;
    logic [15:0] l1_req_wdata;
    logic        l1_req_ready;
    logic        l1_resp_valid;
    logic [15:0] l1_resp_rdata;
    logic        l1_resp_err;
    logic        l1_busy;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] ref_mem   [DEPTH];
    bit          ref_known [DEPTH];

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .busy       (busy)
    );

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(1)) dut_l1 (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (l1_req_valid),
        .req_write  (l1_req_write),
        .req_addr   (l1_req_addr),
        .req_wdata  (l1_req_wdata),
        .req_ready  (l1_req_ready),
        .resp_valid (l1_resp_valid),
        .resp_rdata (l1_resp_rdata),
        .resp_err   (l1_resp_err),
        .busy       (l1_busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic bit addr_err(input logic [15:0] a);
        return (a[0] == 1'b1) || (int'(a >> 1) >= DEPTH);
    endfunction

    // One full transaction on the LATENCY=4 instance. With noise set,
    // random requests are presented while the responder is busy.
    task automatic run_req(input logic w, input logic [15:0] a, input logic [15:0] d, input bit noise);
        bit          e;
        int          idx;
        int          c;
        bit          data_known;
        logic [15:0] want_rd;
        e          = addr_err(a);
        idx        = int'(a >> 1);
        data_known = 1'b1;
        want_rd    = 16'h0000;
        if (!w && !e) begin
            data_known = ref_known[idx];
            want_rd    = ref_mem[idx];
        end

        @(negedge clk);
        check("ready_idle", req_ready, 1);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        @(posedge clk);
        #1;
        c = 1;
        while (!resp_valid && c <= LAT + 3) begin
            check("ready_low", req_ready, 0);
            check("busy_high", busy, 1);
            @(negedge clk);
            if (noise) begin
                req_valid = 1'b1;
                req_write = 1'($urandom_range(0, 1));
                req_addr  = 16'($urandom);
                req_wdata = 16'($urandom);
            end else begin
                req_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            c++;
        end
        check("resp_latency", c, LAT);
        check("resp_valid", resp_valid, 1);
        check("resp_err", resp_err, e);
        check("resp_ready_low", req_ready, 0);
        if (data_known) check("resp_rdata", resp_rdata, want_rd);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        check("resp_one_cycle", resp_valid, 0);
        check("ready_after", req_ready, 1);
        check("busy_after", busy, 0);

        if (w && !e) begin
            ref_mem[idx]   = d;
            ref_known[idx] = 1'b1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int          pool [8];
        int          pick;
        int          seen;
        logic [15:0] a;
        logic        w;

        pool = '{0, 1, 8, 16, 100, 255, 510, 511};
        rst = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        l1_req_valid = 1'b0; l1_req_write = 1'b0; l1_req_addr = '0; l1_req_wdata = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", req_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_rdata", resp_rdata, 0);
        check("rst_err", resp_err, 0);
        check("rst_l1_ready", l1_req_ready, 1);
        @(negedge clk);
        rst = 1'b0;

        // basic store/load
        run_req(1'b1, 16'h0010, 16'hBEEF, 1'b0);
        run_req(1'b0, 16'h0010, 16'h0000, 1'b0);
        // misaligned
        run_req(1'b1, 16'h0021, 16'h1234, 1'b0);
        run_req(1'b0, 16'h0021, 16'h0000, 1'b0);
        run_req(1'b0, 16'h0020, 16'h0000, 1'b0);
        // range boundary
        run_req(1'b0, 16'h0400, 16'h0000, 1'b0);
        run_req(1'b1, 16'h0400, 16'h9999, 1'b0);
        run_req(1'b1, 16'h03FE, 16'h5A5A, 1'b0);
        run_req(1'b0, 16'h03FE, 16'h0000, 1'b0);
        run_req(1'b0, 16'h0000, 16'h0000, 1'b0);
        // inputs toggling while busy
        run_req(1'b1, 16'h0030, 16'h7777, 1'b1);
        run_req(1'b0, 16'h0030, 16'h0000, 1'b1);

        // reset in the middle of a store
        run_req(1'b1, 16'h0008, 16'h1357, 1'b0);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0008; req_wdata = 16'hAAAA;
        @(posedge clk);
        #1;
        check("midrst_ready_c1", req_ready, 0);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_ready", req_ready, 1);
        check("midrst_busy", busy, 0);
        check("midrst_resp_valid", resp_valid, 0);
        check("midrst_rdata", resp_rdata, 0);
        check("midrst_err", resp_err, 0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (resp_valid) seen++;
        end
        check("midrst_no_resp", seen, 0);
        run_req(1'b0, 16'h0008, 16'h0000, 1'b0);

        // reset wins over a request in IDLE
        @(negedge clk);
        rst = 1'b1; req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0010;
        @(posedge clk);
        #1;
        check("rstreq_ready", req_ready, 1);
        @(negedge clk);
        rst = 1'b0; req_valid = 1'b0;
        seen = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (resp_valid) seen++;
        end
        check("rstreq_no_resp", seen, 0);

        // LATENCY=1: back-to-back store then load
        @(negedge clk);
        l1_req_valid = 1'b1; l1_req_write = 1'b1; l1_req_addr = 16'h0044; l1_req_wdata = 16'hC0DE;
        @(posedge clk);
        #1;
        check("l1_store_valid", l1_resp_valid, 1);
        check("l1_store_err", l1_resp_err, 0);
        check("l1_store_rdata", l1_resp_rdata, 0);
        check("l1_store_ready", l1_req_ready, 0);
        @(negedge clk);
        l1_req_write = 1'b0; l1_req_wdata = 16'h0000;
        @(posedge clk);
        #1;
        check("l1_gap_valid", l1_resp_valid, 0);
        check("l1_gap_ready", l1_req_ready, 1);
        @(posedge clk);
        #1;
        check("l1_load_valid", l1_resp_valid, 1);
        check("l1_load_rdata", l1_resp_rdata, 16'hC0DE);
        check("l1_load_err", l1_resp_err, 0);
        @(negedge clk);
        l1_req_valid = 1'b0;
        @(posedge clk);
        #1;
        check("l1_after_valid", l1_resp_valid, 0);
        check("l1_after_ready", l1_req_ready, 1);

        // randomized traffic
        for (int i = 0; i < 40; i++) begin
            pick = $urandom_range(0, 9);
            if (pick < 6)
                a = 16'(pool[$urandom_range(0, 7)] * 2);
            else if (pick < 8)
                a = 16'($urandom_range(0, 1023)) | 16'h0001;
            else
                a = 16'($urandom_range(1024, 65535));
            w = 1'($urandom_range(0, 1));
            run_req(w, a, 16'($urandom), (i % 4) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
